// File: rtl/halfband_mac_sched.sv
// Time-multiplexed 15-tap symmetric halfband FIR: one shared 18x18 multiplier walks the
// four symmetric pre-added pairs plus the centre tap for every accepted input sample.
module halfband_mac_sched #(
    parameter int WIDTH     = 18,
    parameter int LENGTH    = 15,
    parameter int NNZ       = 5,
    parameter int ACCW      = 40,
    parameter int OUT_SHIFT = 16
) (
    input  logic                    sys_clk,
    input  logic                    reset,
    input  logic                    sam_clk_en,
    input  logic signed [WIDTH-1:0] x_in,
    output logic signed [WIDTH-1:0] y,
    output logic                    y_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int KW     = $clog2(NNZ);
    localparam int PW     = 2 * WIDTH;
    localparam int CENTRE = (LENGTH - 1) / 2;
    localparam int YMAX_I = (1 << (WIDTH - 1)) - 1;
    localparam int YMIN_I = -(1 << (WIDTH - 1));
    localparam logic signed [ACCW-1:0] Y_MAX = ACCW'(YMAX_I);
    localparam logic signed [ACCW-1:0] Y_MIN = ACCW'(YMIN_I);
    localparam logic [KW-1:0] K_LAST = KW'(NNZ - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t                  state_reg;
    logic [KW-1:0]           k_reg;
    logic signed [ACCW-1:0]  acc_reg;
    logic                    pend_reg;
    logic signed [WIDTH-1:0] pend_sample_reg;
    logic signed [WIDTH-1:0] x_line_reg [LENGTH];
    logic signed [WIDTH-1:0] y_reg;
    logic                    y_valid_reg;
    logic                    busy_reg;
    logic                    overrun_reg;

    logic signed [WIDTH-1:0] x_halved;
    logic signed [WIDTH-1:0] line_in;
    logic                    start;
    logic signed [WIDTH-1:0] pair_arr [NNZ];
    logic signed [WIDTH-1:0] pair_sel;
    logic signed [WIDTH-1:0] coeff;
    logic signed [PW-1:0]    prod;
    logic signed [ACCW-1:0]  acc_shr;
    logic signed [WIDTH-1:0] y_sat;

    // Input is halved on entry so the 18-bit pair pre-add can never overflow.
    assign x_halved = x_in >>> 1;

    // A new sample starts from IDLE or straight out of OUT; a pending sample always wins.
    assign start   = ((state_reg == IDLE) || (state_reg == OUT)) && (sam_clk_en || pend_reg);
    assign line_in = pend_reg ? pend_sample_reg : x_halved;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            x_line_reg[0] <= '0;
        end else if (start) begin
            x_line_reg[0] <= line_in;
        end
    end

    generate
        for (genvar gi = 1; gi < LENGTH; gi++) begin : g_line
            always_ff @(posedge sys_clk) begin
                if (reset) begin
                    x_line_reg[gi] <= '0;
                end else if (start) begin
                    x_line_reg[gi] <= x_line_reg[gi-1];
                end
            end
        end

        // Only even taps and the centre carry non-zero coefficients.
        for (genvar gi = 0; gi < NNZ - 1; gi++) begin : g_pair
            assign pair_arr[gi] = x_line_reg[2*gi] + x_line_reg[LENGTH-1-2*gi];
        end
    endgenerate

    assign pair_arr[NNZ-1] = x_line_reg[CENTRE];
    assign pair_sel        = pair_arr[k_reg];

    always_comb begin
        coeff = '0;
        case (k_reg)
            KW'(0):  coeff = WIDTH'(-174);
            KW'(1):  coeff = WIDTH'(1637);
            KW'(2):  coeff = WIDTH'(-7962);
            KW'(3):  coeff = WIDTH'(39267);
            KW'(4):  coeff = WIDTH'(65536);
            default: coeff = '0;
        endcase
    end

    assign prod    = coeff * pair_sel;
    assign acc_shr = acc_reg >>> OUT_SHIFT;

    always_comb begin
        y_sat = acc_shr[WIDTH-1:0];
        if (acc_shr > Y_MAX) begin
            y_sat = WIDTH'(YMAX_I);
        end else if (acc_shr < Y_MIN) begin
            y_sat = WIDTH'(YMIN_I);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            k_reg           <= '0;
            acc_reg         <= '0;
            pend_reg        <= 1'b0;
            pend_sample_reg <= '0;
            y_reg           <= '0;
            y_valid_reg     <= 1'b0;
            busy_reg        <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            y_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg   <= '0;
                        k_reg     <= '0;
                        state_reg <= MAC;
                        busy_reg  <= 1'b1;
                        pend_reg  <= 1'b0;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + ACCW'(prod);
                    if (k_reg == K_LAST) begin
                        state_reg <= OUT;
                    end else begin
                        k_reg <= k_reg + KW'(1);
                    end
                    // One-deep pending slot; a second strobe overwrites it and flags the loss.
                    if (sam_clk_en) begin
                        pend_sample_reg <= x_halved;
                        pend_reg        <= 1'b1;
                        if (pend_reg) begin
                            overrun_reg <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    y_reg       <= y_sat;
                    y_valid_reg <= 1'b1;
                    if (start) begin
                        acc_reg   <= '0;
                        k_reg     <= '0;
                        state_reg <= MAC;
                        busy_reg  <= 1'b1;
                        // Pending sample is consumed; a coincident strobe takes its place.
                        pend_reg  <= pend_reg && sam_clk_en;
                        if (pend_reg && sam_clk_en) begin
                            pend_sample_reg <= x_halved;
                        end
                    end else begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign y       = y_reg;
    assign y_valid = y_valid_reg;
    assign busy    = busy_reg;
    assign overrun = overrun_reg;

endmodule
